// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared definitions for the memory arbiter. This package holds
//            the FSM state encoding, the access-size codes, the exception
//            cause codes, the owner identifiers and the byte-enable mask
//            helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Access size codes carried on ls_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Exception cause codes reported with err
    localparam logic [3:0] CAUSE_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_LS_MISALIGN    = 4'd2;
    localparam logic [3:0] CAUSE_BUS_TIMEOUT    = 4'd5;

    // Transaction owner / last-grant identifiers
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    // Unshifted byte-enable mask for an access of the given size.
    // Unknown size codes behave as a full word.
    function automatic logic [3:0] size_be_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001;
            SIZE_H:  mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Purely combinational lane steering for one memory access.
//            It produces the byte enables and the replicated write data,
//            and it flags accesses that are not naturally aligned.
// Ports    : addr_lo    in  2   low address bits of the access
//            size       in  2   SIZE_B / SIZE_H / SIZE_W
//            wdata_in   in  32  right-aligned store data
//            be         out 4   byte enables (valid when aligned)
//            wdata_out  out 32  lane-replicated store data
//            misaligned out 1   access violates natural alignment
// Revision : 1.0  initial release
// ============================================================================
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b1111;
        wdata_out  = wdata_in;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be        = size_be_mask(SIZE_B) << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
            end
            SIZE_H: begin
                be         = size_be_mask(SIZE_H) << addr_lo;
                wdata_out  = {2{wdata_in[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                // Word (and any unknown code) must sit on a word boundary
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : This block arbitrates between the instruction-fetch (IF) and
//            load/store (LS) requesters for a single memory port. Only one
//            transaction is in flight at a time. Ties are broken
//            round-robin. Misaligned accesses are rejected without touching
//            memory. Accesses that receive no mem_ready within TIMEOUT
//            cycles end in a bus-timeout error.
// Params   : TIMEOUT  max ACCESS cycles without mem_ready (>= 1)
// Ports    : clk, rst_n                      clock, async active-low reset
//            if_req, if_addr                 IF request (always word read)
//            ls_req, ls_addr, ls_we,
//            ls_size, ls_wdata               LS request
//            if_ack/err/cause, ls_ack/err/cause  one-cycle completion
//            rdata                           last captured read word
//            mem_req, mem_addr, mem_we,
//            mem_be, mem_wdata               memory request
//            mem_ready, mem_rdata            memory completion
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        if_ack,
    output logic        if_err,
    output logic [3:0]  if_cause,
    output logic        ls_ack,
    output logic        ls_err,
    output logic [3:0]  ls_cause,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // The wait counter only has to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(TIMEOUT - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_owner;
    logic             r_last;
    logic             r_err_pend;
    logic [3:0]       r_cause_pend;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_any_req;
    logic             w_pick_ls;
    logic [31:0]      w_sel_addr;
    logic [1:0]       w_sel_size;
    logic [31:0]      w_sel_wdata;
    logic             w_sel_we;
    logic [3:0]       w_lane_be;
    logic [31:0]      w_lane_wdata;
    logic             w_misaligned;

    logic             w_grant;
    logic             w_capture;
    logic             w_expire;
    logic             w_wait;
    logic             w_respond;

    // ------------------------------------------------------------------
    // Request selection: LS wins when it is alone, or when both requesters
    // are asking and IF was served last.
    // ------------------------------------------------------------------
    assign w_any_req   = if_req | ls_req;
    assign w_pick_ls   = ls_req & (~if_req | (r_last == OWNER_IF));
    assign w_sel_addr  = w_pick_ls ? ls_addr  : if_addr;
    assign w_sel_size  = w_pick_ls ? ls_size  : SIZE_W;
    assign w_sel_wdata = w_pick_ls ? ls_wdata : 32'd0;
    assign w_sel_we    = w_pick_ls & ls_we;

    mem_lane_align u_lane_align (
        .addr_lo    (w_sel_addr[1:0]),
        .size       (w_sel_size),
        .wdata_in   (w_sel_wdata),
        .be         (w_lane_be),
        .wdata_out  (w_lane_wdata),
        .misaligned (w_misaligned)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        w_wait      = 1'b0;
        w_respond   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = w_misaligned ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // mem_ready takes priority over a simultaneous timeout
                if (mem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_wait = 1'b1;
                end
            end
            ST_RESP: begin
                w_respond   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: grant latching, memory request, read capture, response.
    // The ack/err/cause outputs are registered out of RESP. They are
    // therefore visible during the IDLE cycle that follows RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWNER_IF;
            r_last       <= OWNER_LS;
            r_err_pend   <= 1'b0;
            r_cause_pend <= 4'd0;
            r_wait_cnt   <= '0;
            if_ack       <= 1'b0;
            if_err       <= 1'b0;
            if_cause     <= 4'd0;
            ls_ack       <= 1'b0;
            ls_err       <= 1'b0;
            ls_cause     <= 4'd0;
            rdata        <= 32'd0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            mem_we       <= 1'b0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
        end else begin
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_cause <= 4'd0;
            ls_ack   <= 1'b0;
            ls_err   <= 1'b0;
            ls_cause <= 4'd0;

            if (w_grant) begin
                r_owner    <= w_pick_ls;
                r_wait_cnt <= '0;
                if (w_misaligned) begin
                    r_err_pend   <= 1'b1;
                    r_cause_pend <= w_pick_ls ? CAUSE_LS_MISALIGN : CAUSE_IADDR_MISALIGN;
                end else begin
                    r_err_pend   <= 1'b0;
                    r_cause_pend <= 4'd0;
                    mem_req      <= 1'b1;
                    mem_addr     <= {w_sel_addr[31:2], 2'b00};
                    mem_we       <= w_sel_we;
                    mem_be       <= w_lane_be;
                    mem_wdata    <= w_lane_wdata;
                end
            end

            if (w_wait) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                rdata   <= mem_rdata;
                mem_req <= 1'b0;
            end

            if (w_expire) begin
                mem_req      <= 1'b0;
                r_err_pend   <= 1'b1;
                r_cause_pend <= CAUSE_BUS_TIMEOUT;
            end

            if (w_respond) begin
                r_last <= r_owner;
                if (r_owner == OWNER_LS) begin
                    ls_ack   <= 1'b1;
                    ls_err   <= r_err_pend;
                    ls_cause <= r_cause_pend;
                end else begin
                    if_ack   <= 1'b1;
                    if_err   <= r_err_pend;
                    if_cause <= r_cause_pend;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. It runs directed
//            scenarios followed by randomized arbitration rounds. The
//            results are compared against a transaction-level reference
//            model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TO     = 8;
    localparam int ROUNDS = 200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        ls_req = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        if_ack, if_err, ls_ack, ls_err;
    logic [3:0]  if_cause, ls_cause;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .ls_req    (ls_req),
        .ls_addr   (ls_addr),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_wdata  (ls_wdata),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .if_cause  (if_cause),
        .ls_ack    (ls_ack),
        .ls_err    (ls_err),
        .ls_cause  (ls_cause),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending requests and arbitration history
    bit          p_if, p_ls;
    logic [31:0] m_if_addr, m_ls_addr, m_ls_wdata;
    logic [1:0]  m_ls_size;
    bit          m_ls_we;
    bit          m_last_ls;
    logic [31:0] m_rdata;

    // Observations captured in the most recent round
    bit          g_win_ls;
    logic [3:0]  g_be;
    logic [31:0] g_wdata, g_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] a);
        return (a % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
        int unsigned mask;
        mask = (32'd1 << nbytes(size)) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (size == 2'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] quiet();
        return {20'd0, if_ack, ls_ack, if_err, ls_err, if_cause, ls_cause};
    endfunction

    task automatic drive_requests();
        if_req   = p_if;
        if_addr  = m_if_addr;
        ls_req   = p_ls;
        ls_addr  = m_ls_addr;
        ls_we    = m_ls_we;
        ls_size  = m_ls_size;
        ls_wdata = m_ls_wdata;
    endtask

    // Asserts reset mid-cycle, checks that every output clears at once,
    // then releases on a falling edge and resets the model.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctl", {14'd0, if_ack, ls_ack, if_err, ls_err, if_cause, ls_cause,
                          mem_req, mem_we, mem_be}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
        p_if = 1'b0; p_ls = 1'b0; m_last_ls = 1'b1; m_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One arbitration round. It starts on a falling edge with the DUT in IDLE.
    // k is the ACCESS cycle (1-based) in which mem_ready is given; values
    // above TO mean memory never answers. rd is the word returned.
    task automatic run_round(input int k, input logic [31:0] rd);
        bit          win_ls, bad, exp_err, we;
        logic [31:0] a, wd, e_owner;
        logic [1:0]  sz;
        logic [3:0]  exp_cause;
        int          w, ack_at;
        drive_requests();
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!p_if && !p_ls) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_quiet", quiet(), 32'd0);
            check("idle_memreq", mem_req, 32'd0);
            return;
        end
        win_ls = p_ls && (!p_if || !m_last_ls);
        if (win_ls) begin
            a = m_ls_addr; sz = m_ls_size; we = m_ls_we; wd = m_ls_wdata;
        end else begin
            a = m_if_addr; sz = 2'd2; we = 1'b0; wd = 32'd0;
        end
        bad       = model_misaligned(sz, a);
        w         = (k < TO) ? k : TO;
        exp_err   = bad || (k > TO);
        exp_cause = bad ? (win_ls ? 4'd2 : 4'd0) : (exp_err ? 4'd5 : 4'd0);
        ack_at    = bad ? 2 : w + 2;
        for (int cyc = 1; cyc <= ack_at; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc < ack_at) check("no_ack_yet", quiet(), 32'd0);
            if (!bad && cyc <= w) begin
                check("mem_req_hi", mem_req, 32'd1);
                check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                check("mem_be", mem_be, model_be(sz, a));
                check("mem_we", mem_we, we);
                check("mem_wdata", mem_wdata, model_wdata(sz, wd));
                if (cyc == 1) begin
                    g_be = mem_be; g_wdata = mem_wdata; g_addr = mem_addr;
                end
            end else begin
                check("mem_req_lo", mem_req, 32'd0);
            end
            if (cyc == ack_at) begin
                check("owner_ack", win_ls ? ls_ack : if_ack, 32'd1);
                check("other_ack", win_ls ? if_ack : ls_ack, 32'd0);
                e_owner = win_ls ? {27'd0, ls_err, ls_cause} : {27'd0, if_err, if_cause};
                check("owner_err_cause", e_owner, {27'd0, exp_err, exp_cause});
                check("other_err_cause", win_ls ? {27'd0, if_err, if_cause}
                                                : {27'd0, ls_err, ls_cause}, 32'd0);
                if (!exp_err) m_rdata = rd;
                check("rdata", rdata, m_rdata);
            end
            // The winner's inputs must be ignored once granted
            if (cyc == 1) begin
                if (win_ls) begin
                    ls_addr = $urandom; ls_wdata = $urandom;
                    ls_size = 2'($urandom_range(0, 3)); ls_we = 1'($urandom_range(0, 1));
                end else begin
                    if_addr = $urandom;
                end
            end
            if (!bad && cyc <= w) begin
                mem_ready = (cyc == k);
                mem_rdata = (cyc == k) ? rd : $urandom;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
        if (win_ls) p_ls = 1'b0;
        else        p_if = 1'b0;
        m_last_ls = win_ls;
        g_win_ls  = win_ls;
    endtask

    task automatic new_requests();
        if (!p_if && $urandom_range(0, 1) == 1) begin
            p_if = 1'b1;
            m_if_addr = $urandom;
            if ($urandom_range(0, 3) != 0) m_if_addr = m_if_addr & 32'hFFFF_FFFC;
        end
        if (!p_ls && $urandom_range(0, 1) == 1) begin
            p_ls = 1'b1;
            m_ls_size  = 2'($urandom_range(0, 2));
            m_ls_addr  = $urandom;
            if ($urandom_range(0, 2) != 0)
                m_ls_addr = m_ls_addr & ~(32'(nbytes(m_ls_size)) - 32'd1);
            m_ls_we    = 1'($urandom_range(0, 1));
            m_ls_wdata = $urandom;
        end
    endtask

    function automatic int pick_delay();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return TO + 40;
        if (sel == 1) return TO;
        return $urandom_range(1, 4);
    endfunction

    initial begin
        m_if_addr = 0; m_ls_addr = 0; m_ls_wdata = 0; m_ls_size = 0; m_ls_we = 0;
        g_win_ls = 0; g_be = 0; g_wdata = 0; g_addr = 0;
        do_reset();

        // IF word fetch, memory answers in the third ACCESS cycle
        p_if = 1'b1; m_if_addr = 32'h0000_0010;
        run_round(3, 32'h0000_0013);
        check("if_fetch_rdata", rdata, 32'h0000_0013);

        // LS byte store to 0x403
        p_ls = 1'b1; m_ls_addr = 32'h403; m_ls_size = 2'd0; m_ls_we = 1'b1; m_ls_wdata = 32'h34;
        run_round(1, $urandom);
        check("sb_be", g_be, 32'h8);
        check("sb_wdata", g_wdata, 32'h3434_3434);
        check("sb_addr", g_addr, 32'h400);

        // LS misaligned word load
        p_ls = 1'b1; m_ls_addr = 32'h402; m_ls_size = 2'd2; m_ls_we = 1'b0; m_ls_wdata = 32'd0;
        run_round(1, $urandom);

        // Memory never answers: bus timeout
        p_if = 1'b1; m_if_addr = 32'h0000_0080;
        run_round(TO + 40, $urandom);
        check("timeout_memreq", mem_req, 32'd0);

        // Reset in the middle of an access
        p_if = 1'b1; m_if_addr = 32'h0000_0100;
        drive_requests();
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_memreq", mem_req, 32'd1);
        do_reset();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_ready_quiet", quiet(), 32'd0);
        check("late_ready_memreq", mem_req, 32'd0);
        check("late_ready_rdata", rdata, 32'd0);
        mem_ready = 1'b0;
        p_if = 1'b1; m_if_addr = 32'h0000_0020;
        run_round(1, 32'hCAFE_0001);
        check("post_rst_rdata", rdata, 32'hCAFE_0001);

        // Both requesters held continuously after reset: IF, LS, IF, LS
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            p_if = 1'b1; m_if_addr = 32'h0000_1000 + 32'(i * 4);
            p_ls = 1'b1; m_ls_addr = 32'h0000_2000 + 32'(i * 4);
            m_ls_size = 2'd2; m_ls_we = 1'b0; m_ls_wdata = 32'd0;
            run_round(1, $urandom);
            check("alt_grant", 32'(g_win_ls), 32'(i % 2));
        end

        // Randomized rounds
        for (int r = 0; r < ROUNDS; r++) begin
            new_requests();
            run_round(pick_delay(), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
